// File: rtl/lsu_controller.sv
// Load/store unit: single-outstanding loads and stores against a big-endian,
// word-wide memory port; sub-word stores are done as read-modify-write.
module lsu_controller #(
    parameter int MEM_ADDR_BITS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_data,
    output logic        o_fault,
    output logic [31:0] o_mem_r_addr,
    input  logic [31:0] i_mem_r_data,
    output logic [31:0] o_mem_w_addr,
    output logic [31:0] o_mem_w_data,
    output logic        o_mem_w_en
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  op_q;
    logic [31:0] wdata_q;
    logic [31:0] r_addr_q, r_addr_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        w_en_q, w_en_d;
    logic        resp_valid_q, resp_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        accept_s;
    logic        req_fault_s;

    function automatic logic op_legal(input logic we, input logic [2:0] op);
        if (we) begin
            op_legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
        end else begin
            op_legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                       (op == 3'b100) || (op == 3'b101);
        end
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [31:0] addr);
        case (op[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    // The memory returns {M[A],M[A+1],M[A+2],M[A+3]}, so sub-words sit at the top.
    function automatic logic [31:0] load_format(input logic [2:0] op, input logic [31:0] r);
        case (op)
            3'b000:  load_format = {{24{r[31]}}, r[31:24]};
            3'b100:  load_format = {24'd0, r[31:24]};
            3'b001:  load_format = {{16{r[31]}}, r[31:16]};
            3'b101:  load_format = {16'd0, r[31:16]};
            default: load_format = r;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [31:0] r,
                                                input logic [31:0] wd);
        case (op)
            3'b000:  store_merge = {wd[7:0], r[23:0]};
            3'b001:  store_merge = {wd[15:0], r[15:0]};
            default: store_merge = wd;
        endcase
    endfunction

    assign o_req_ready  = (state_q == S_IDLE) && !i_rst;
    assign accept_s     = i_req_valid && o_req_ready;
    assign req_fault_s  = !op_legal(i_req_we, i_req_op) ||
                          ((i_req_addr >> MEM_ADDR_BITS) != 32'd0) ||
                          misaligned(i_req_op, i_req_addr);

    assign o_resp_valid = resp_valid_q;
    assign o_resp_data  = resp_data_q;
    assign o_fault      = fault_q;
    assign o_mem_r_addr = r_addr_q;
    assign o_mem_w_addr = w_addr_q;
    assign o_mem_w_data = w_data_q;
    assign o_mem_w_en   = w_en_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        r_addr_d     = r_addr_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        w_en_d       = 1'b0;
        resp_valid_d = 1'b0;
        fault_d      = 1'b0;
        resp_data_d  = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    r_addr_d = i_req_addr;
                    if (req_fault_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end else if (i_req_we && (i_req_op == 3'b010)) begin
                        state_d  = S_WR;
                        w_en_d   = 1'b1;
                        w_addr_d = i_req_addr;
                        w_data_d = i_req_wdata;
                    end else begin
                        state_d = S_RD1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                if (we_q) begin
                    state_d  = S_WR;
                    w_en_d   = 1'b1;
                    w_addr_d = r_addr_q;
                    w_data_d = store_merge(op_q, i_mem_r_data, wdata_q);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_format(op_q, i_mem_r_data);
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, request capture and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            op_q         <= 3'd0;
            wdata_q      <= 32'd0;
            r_addr_q     <= 32'd0;
            w_addr_q     <= 32'd0;
            w_data_q     <= 32'd0;
            w_en_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            r_addr_q     <= r_addr_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_en_q       <= w_en_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            resp_data_q  <= resp_data_d;
            if (accept_s) begin
                we_q    <= i_req_we;
                op_q    <= i_req_op;
                wdata_q <= i_req_wdata;
            end else begin
                we_q    <= we_q;
                op_q    <= op_q;
                wdata_q <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: byte-array memory model plus a
// byte-level reference model of load/store semantics.
module tb_lsu_controller;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_op = 3'd0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_resp_valid;
    logic [31:0] o_resp_data;
    logic        o_fault;
    logic [31:0] o_mem_r_addr;
    logic [31:0] i_mem_r_data;
    logic [31:0] o_mem_w_addr;
    logic [31:0] o_mem_w_data;
    logic        o_mem_w_en;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_word = 32'd0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] kd;
        logic [31:0] kw;
    } req_t;

    lsu_controller #(.MEM_ADDR_BITS(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_op(i_req_op),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_fault(o_fault),
        .o_mem_r_addr(o_mem_r_addr), .i_mem_r_data(i_mem_r_data),
        .o_mem_w_addr(o_mem_w_addr), .o_mem_w_data(o_mem_w_data), .o_mem_w_en(o_mem_w_en)
    );

    always #5 i_clk = ~i_clk;

    // Memory: registered big-endian word read, word write, bench preload port.
    always @(posedge i_clk) begin
        for (int j = 0; j < 4; j++) begin
            if (pre_en) mem[pre_addr + 8'(j)] <= pre_word[31 - 8*j -: 8];
            if (o_mem_w_en) mem[o_mem_w_addr[7:0] + 8'(j)] <= o_mem_w_data[31 - 8*j -: 8];
        end
        i_mem_r_data <= {mem[o_mem_r_addr[7:0]], mem[o_mem_r_addr[7:0] + 8'd1],
                         mem[o_mem_r_addr[7:0] + 8'd2], mem[o_mem_r_addr[7:0] + 8'd3]};
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        @(negedge i_clk);
        pre_en = 1'b1; pre_addr = a; pre_word = w;
        for (int j = 0; j < 4; j++) ref_mem[a + 8'(j)] = w[31 - 8*j -: 8];
        @(negedge i_clk);
        pre_en = 1'b0;
    endtask

    // Reference behaviour from the byte-array view; updates ref_mem on stores.
    task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output logic f, output logic [31:0] d,
                         output int lat, output logic wen, output logic [31:0] ww);
        logic legal;
        int   size;
        int   a;
        legal = we ? (op <= 3'd2) : (op <= 3'd2 || op == 3'd4 || op == 3'd5);
        size  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        f     = !legal || (addr >= 32'd256) || ((addr % size) != 0);
        d = 32'd0; wen = 1'b0; ww = 32'd0; lat = 1;
        a = int'(addr % 256);
        if (f) begin
            lat = 1;
        end else if (!we) begin
            lat = 3;
            if (size == 1) begin
                d = {24'd0, ref_mem[a]};
                if (op == 3'b000 && d >= 32'd128) d = d - 32'd256;
            end else if (size == 2) begin
                d = {16'd0, ref_mem[a], ref_mem[(a + 1) % 256]};
                if (op == 3'b001 && d >= 32'd32768) d = d - 32'd65536;
            end else begin
                d = {ref_mem[a], ref_mem[(a + 1) % 256], ref_mem[(a + 2) % 256], ref_mem[(a + 3) % 256]};
            end
        end else begin
            lat = (size == 4) ? 2 : 4;
            wen = 1'b1;
            for (int i = 0; i < size; i++) ref_mem[(a + i) % 256] = 8'(wd >> (8 * (size - 1 - i)));
            ww = {ref_mem[a], ref_mem[(a + 1) % 256], ref_mem[(a + 2) % 256], ref_mem[(a + 3) % 256]};
        end
    endtask

    // Issue one request and observe response latency, fault, data and write pulses.
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic f,
                          output logic [31:0] d, output int wcnt, output logic [31:0] wa,
                          output logic [31:0] wdat);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        i_req_valid = 1'b1; i_req_we = we; i_req_op = op; i_req_addr = addr; i_req_wdata = wd;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        lat = -1; f = 1'b0; d = 32'd0; wcnt = 0; wa = 32'd0; wdat = 32'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (o_mem_w_en) begin
                wcnt++; wa = o_mem_w_addr; wdat = o_mem_w_data;
            end
            if (o_resp_valid) begin
                lat = k; f = o_fault; d = o_resp_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_req_ready !== 1'b0 || o_resp_valid !== 1'b0 || o_fault !== 1'b0 || o_resp_data !== 32'd0 ||
            o_mem_r_addr !== 32'd0 || o_mem_w_addr !== 32'd0 || o_mem_w_data !== 32'd0 || o_mem_w_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b rv=%b f=%b rd=%h ra=%h wa=%h wd=%h we=%b want all 0",
                     o_req_ready, o_resp_valid, o_fault, o_resp_data, o_mem_r_addr, o_mem_w_addr, o_mem_w_data, o_mem_w_en);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", o_req_ready);
        end
    endtask

    task automatic test_directed();
        req_t tbl [16];
        int lat, wcnt, xlat;
        logic f, xf, xwen;
        logic [31:0] d, wa, wdat, xd, xww;
        tbl[0]  = '{1'b0, 3'b000, 32'd16,    32'd0,        32'hFFFFFF80, 32'd0};
        tbl[1]  = '{1'b0, 3'b100, 32'd16,    32'd0,        32'h00000080, 32'd0};
        tbl[2]  = '{1'b0, 3'b001, 32'd16,    32'd0,        32'hFFFF8012, 32'd0};
        tbl[3]  = '{1'b0, 3'b101, 32'd16,    32'd0,        32'h00008012, 32'd0};
        tbl[4]  = '{1'b0, 3'b010, 32'd16,    32'd0,        32'h80123456, 32'd0};
        tbl[5]  = '{1'b1, 3'b010, 32'd8,     32'hDEADBEEF, 32'd0,        32'hDEADBEEF};
        tbl[6]  = '{1'b0, 3'b010, 32'd8,     32'd0,        32'hDEADBEEF, 32'd0};
        tbl[7]  = '{1'b1, 3'b000, 32'd32,    32'h123456AB, 32'd0,        32'hAB223344};
        tbl[8]  = '{1'b1, 3'b001, 32'd34,    32'h9876CAFE, 32'd0,        32'hCAFE5566};
        tbl[9]  = '{1'b0, 3'b010, 32'd32,    32'd0,        32'hAB22CAFE, 32'd0};
        tbl[10] = '{1'b0, 3'b010, 32'h2,     32'd0,        32'd0,        32'd0};
        tbl[11] = '{1'b1, 3'b001, 32'h5,     32'h1111,     32'd0,        32'd0};
        tbl[12] = '{1'b0, 3'b000, 32'h100,   32'd0,        32'd0,        32'd0};
        tbl[13] = '{1'b0, 3'b011, 32'd16,    32'd0,        32'd0,        32'd0};
        tbl[14] = '{1'b1, 3'b100, 32'd16,    32'd0,        32'd0,        32'd0};
        tbl[15] = '{1'b0, 3'b101, 32'h1FF,   32'd0,        32'd0,        32'd0};
        preload(8'd16, 32'h80123456);
        preload(8'd32, 32'h11223344);
        preload(8'd36, 32'h55667788);
        for (int i = 0; i < 16; i++) begin
            model(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd, xf, xd, xlat, xwen, xww);
            do_req(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd, lat, f, d, wcnt, wa, wdat);
            checks++;
            if (lat !== xlat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, xlat); end
            checks++;
            if (f !== xf) begin errors++; $display("FAIL dir%0d_fault: got %b want %b", i, f, xf); end
            checks++;
            if (d !== xd || d !== tbl[i].kd) begin
                errors++; $display("FAIL dir%0d_data: got %h want %h (table %h)", i, d, xd, tbl[i].kd);
            end
            checks++;
            if (wcnt !== (xwen ? 1 : 0)) begin errors++; $display("FAIL dir%0d_wcount: got %0d want %0d", i, wcnt, xwen ? 1 : 0); end
            if (xwen) begin
                checks++;
                if (wa !== tbl[i].addr || wdat !== xww || wdat !== tbl[i].kw) begin
                    errors++;
                    $display("FAIL dir%0d_write: got addr %h data %h want addr %h data %h (table %h)",
                             i, wa, wdat, tbl[i].addr, xww, tbl[i].kw);
                end
            end
        end
        checks++;
        if (mem[33] !== 8'h22) begin errors++; $display("FAIL byte33_kept: got %h want 22", mem[33]); end
    endtask

    task automatic test_random();
        int lat, wcnt, xlat, size, sel;
        logic f, xf, xwen, we;
        logic [2:0] op;
        logic [31:0] d, wa, wdat, xd, xww, addr, wd;
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom % 2);
            op   = 3'($urandom % 8);
            wd   = $urandom;
            size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
            sel  = int'($urandom % 10);
            if (sel < 8) addr = ($urandom % 256) & ~(32'(size) - 32'd1);
            else if (sel == 8) addr = $urandom % 256;
            else addr = 32'd256 + ($urandom % 512);
            model(we, op, addr, wd, xf, xd, xlat, xwen, xww);
            do_req(we, op, addr, wd, lat, f, d, wcnt, wa, wdat);
            checks++;
            if (lat !== xlat || f !== xf || d !== xd) begin
                errors++;
                $display("FAIL rnd%0d_resp (we=%b op=%b addr=%h): got lat %0d f %b d %h want lat %0d f %b d %h",
                         i, we, op, addr, lat, f, d, xlat, xf, xd);
            end
            checks++;
            if (wcnt !== (xwen ? 1 : 0) || (xwen && (wa !== addr || wdat !== xww))) begin
                errors++;
                $display("FAIL rnd%0d_write: got n %0d addr %h data %h want n %0d addr %h data %h",
                         i, wcnt, wa, wdat, xwen ? 1 : 0, addr, xww);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, lat, xlat;
        logic xf, xwen;
        logic [31:0] xd, xww, d;
        model(1'b1, 3'b010, 32'd0, 32'h01020304, xf, xd, xlat, xwen, xww);
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_op = 3'b010; i_req_addr = 32'd0; i_req_wdata = 32'h01020304;
        @(posedge i_clk);
        #1 i_req_we = 1'b0; i_req_wdata = 32'd0;
        acc = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (o_req_ready) begin acc = k; break; end
        end
        checks++;
        if (acc !== 3) begin errors++; $display("FAIL b2b_accept_cycle: got %0d want 3", acc); end
        model(1'b0, 3'b010, 32'd0, 32'd0, xf, xd, xlat, xwen, xww);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        lat = -1; d = 32'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (o_resp_valid) begin lat = k; d = o_resp_data; break; end
        end
        checks++;
        if (lat !== 3 || d !== xd || d !== 32'h01020304) begin
            errors++; $display("FAIL b2b_load: got lat %0d data %h want lat 3 data 01020304", lat, d);
        end
    endtask

    task automatic test_mid_reset();
        int seen, lat, wcnt, xlat;
        logic f, xf, xwen;
        logic [31:0] d, wa, wdat, xd, xww;
        preload(8'd40, 32'h99AABBCC);
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_op = 3'b000; i_req_addr = 32'd40; i_req_wdata = 32'h77;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_req_ready !== 1'b0 || o_resp_valid !== 1'b0 || o_fault !== 1'b0 || o_resp_data !== 32'd0 ||
            o_mem_r_addr !== 32'd0 || o_mem_w_addr !== 32'd0 || o_mem_w_data !== 32'd0 || o_mem_w_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: rdy=%b rv=%b f=%b rd=%h ra=%h wa=%h wd=%h we=%b want all 0",
                     o_req_ready, o_resp_valid, o_fault, o_resp_data, o_mem_r_addr, o_mem_w_addr, o_mem_w_data, o_mem_w_en);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", o_req_ready); end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_resp_valid || o_mem_w_en) seen++;
            @(negedge i_clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d activity cycles want 0", seen); end
        model(1'b0, 3'b010, 32'd40, 32'd0, xf, xd, xlat, xwen, xww);
        do_req(1'b0, 3'b010, 32'd40, 32'd0, lat, f, d, wcnt, wa, wdat);
        checks++;
        if (lat !== 3 || f !== 1'b0 || d !== xd || d !== 32'h99AABBCC) begin
            errors++; $display("FAIL midrst_next_load: got lat %0d f %b data %h want lat 3 f 0 data 99AABBCC", lat, f, d);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        for (int w = 0; w < 64; w++) preload(8'(w * 4), $urandom);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
